// File: rtl/avl_bus_pkg.sv
// Shared Avalon-style bus constants and the address-decode helper used by
// slaves and the bus arbiter.
package avl_bus_pkg;

  localparam int AVL_ADDR_W = 32;
  localparam int AVL_DATA_W = 32;
  localparam int AVL_BE_W   = 4;

  localparam logic [AVL_DATA_W-1:0] AVL_BAD_READ = 32'h0000_0000;

  // True when addr falls in the 2**(width+2)-byte window starting at base.
  function automatic logic avl_in_range(input logic [AVL_ADDR_W-1:0] addr,
                                        input logic [AVL_ADDR_W-1:0] base,
                                        input int                    width);
    return (addr >> (width + 2)) == (base >> (width + 2));
  endfunction

endpackage

// File: rtl/avl_slave_ram_if.sv
// Avalon-style command/response bus between one master and one slave.
interface avl_bus_if;
  import avl_bus_pkg::*;

  logic [AVL_ADDR_W-1:0] address;
  logic [AVL_BE_W-1:0]   byte_en;
  logic                  read;
  logic                  write;
  logic [AVL_DATA_W-1:0] write_data;
  logic                  request_ready;
  logic [AVL_DATA_W-1:0] read_data;
  logic                  read_data_valid;
  logic                  resp_ready;

  modport master (
    output address, byte_en, read, write, write_data, resp_ready,
    input  request_ready, read_data, read_data_valid
  );

  modport slave (
    input  address, byte_en, read, write, write_data, resp_ready,
    output request_ready, read_data, read_data_valid
  );

endinterface

// File: rtl/avl_slave_ram_resp_fifo.sv
// Synchronous response FIFO; the head reads as AVL_BAD_READ while empty.
module avl_resp_fifo
  import avl_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [AVL_DATA_W-1:0]       push_data,
  input  logic                        pop,
  output logic [AVL_DATA_W-1:0]       head,
  output logic                        valid,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AVL_DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    do_pop   = pop && (count_q != {CW{1'b0}});
    do_push  = push && ((count_q != FULL) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Storage is never reset, so the head is masked while empty.
  always_comb begin
    valid = (count_q != {CW{1'b0}});
    count = count_q;
    if (valid) begin
      head = mem_q[rd_ptr_q];
    end else begin
      head = AVL_BAD_READ;
    end
  end

endmodule

// File: rtl/avl_slave_ram.sv
// Word-addressed RAM slave: pipelined read/write commands with back-pressure,
// in-order read responses through a one-entry stage and a response FIFO.
module avl_slave_ram
  import avl_bus_pkg::*;
#(
  parameter logic [AVL_ADDR_W-1:0] ADDR_BASE  = 32'h0000_0000,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    RESP_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rest,
  avl_bus_if.slave i_avl_bus
);

  localparam int WORDS = 2 ** ADDR_WIDTH;
  localparam int CW    = $clog2(RESP_DEPTH) + 1;
  localparam logic [CW:0] OCC_FULL = (CW + 1)'(RESP_DEPTH);

  logic [AVL_DATA_W-1:0] ram_q [WORDS];
  logic [AVL_DATA_W-1:0] stage_data_q;
  logic                  stage_valid_q, stage_valid_d;
  logic                  stage_bad_q, stage_bad_d;

  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  request_ready;
  logic                  accept;
  logic                  accept_wr;
  logic                  accept_rd;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [AVL_DATA_W-1:0] push_data;
  logic [AVL_DATA_W-1:0] fifo_head;
  logic                  fifo_valid;
  logic                  pop;

  // Readiness counts the staged read so the FIFO can always absorb it;
  // writes wait behind reads too, keeping command order intact.
  always_comb begin
    occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, stage_valid_q};
    request_ready = !rest && (occupancy < OCC_FULL);
    accept        = (i_avl_bus.read || i_avl_bus.write) && request_ready;
    accept_wr     = accept && i_avl_bus.write;
    accept_rd     = accept && i_avl_bus.read && !i_avl_bus.write;
    in_range      = avl_in_range(i_avl_bus.address, ADDR_BASE, ADDR_WIDTH);
    word_idx      = i_avl_bus.address[ADDR_WIDTH+1:2];
    stage_valid_d = accept_rd;
    stage_bad_d   = stage_bad_q;
    if (accept_rd) begin
      stage_bad_d = !in_range;
    end else begin
      stage_bad_d = stage_bad_q;
    end
    if (stage_bad_q) begin
      push_data = AVL_BAD_READ;
    end else begin
      push_data = stage_data_q;
    end
    pop = fifo_valid && i_avl_bus.resp_ready;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      stage_valid_q <= 1'b0;
      stage_bad_q   <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_bad_q   <= stage_bad_d;
    end
  end

  // RAM contents survive reset; out-of-range writes are dropped here.
  always_ff @(posedge clk) begin
    if (accept_wr && in_range) begin
      for (int b = 0; b < AVL_BE_W; b++) begin
        if (i_avl_bus.byte_en[b]) begin
          ram_q[word_idx][8*b +: 8] <= i_avl_bus.write_data[8*b +: 8];
        end
      end
    end
    if (accept_rd) begin
      stage_data_q <= ram_q[word_idx];
    end
  end

  avl_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rest),
    .push      (stage_valid_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign i_avl_bus.request_ready   = request_ready;
  assign i_avl_bus.read_data       = fifo_head;
  assign i_avl_bus.read_data_valid = fifo_valid;

endmodule

// File: tb/tb_avl_slave_ram.sv
// Directed and randomized checks of avl_slave_ram against a transaction-level
// model: a word array plus a queue of expected responses tagged by accept edge.
module tb_avl_slave_ram;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          AW    = 10;
  localparam int          DEPTH = 4;
  localparam int          WORDS = 1024;

  typedef struct {
    logic [31:0] data;
    int          e;
  } resp_t;

  logic clk  = 1'b0;
  logic rest = 1'b1;

  avl_bus_if bus();

  avl_slave_ram #(
    .ADDR_BASE  (BASE),
    .ADDR_WIDTH (AW),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rest      (rest),
    .i_avl_bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_m [WORDS];
  resp_t       exp_q [$];
  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_fails  = 0;
  int          obs_acc  = 0;

  function automatic bit m_in_range(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4096);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_in_range(a)) return mem_m[m_idx(a)];
    return 32'h0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (m_in_range(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[m_idx(a)][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  // The front response becomes visible once the edge after its acceptance has passed.
  function automatic bit m_valid();
    return (exp_q.size() > 0) && (exp_q[0].e <= edge_cnt - 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    bit er;
    ev = m_valid();
    er = !rest && (exp_q.size() < DEPTH);
    check_eq("request_ready", {31'd0, bus.request_ready}, {31'd0, er});
    check_eq("read_data_valid", {31'd0, bus.read_data_valid}, {31'd0, ev});
    if (ev) check_eq("read_data", bus.read_data, exp_q[0].data);
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.byte_en    = be;
    bus.write_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
  endtask

  // One clock: decide acceptance/pop from the model, advance it, then check.
  task automatic step();
    bit          pre_rd, pre_wr, acc, pop;
    logic [31:0] a, wd;
    logic [3:0]  be;
    pre_rd = bus.read;
    pre_wr = bus.write;
    a      = bus.address;
    wd     = bus.write_data;
    be     = bus.byte_en;
    acc    = !rest && (pre_rd || pre_wr) && (exp_q.size() < DEPTH);
    pop    = !rest && m_valid() && bus.resp_ready;
    if ((pre_rd || pre_wr) && bus.request_ready === 1'b1) obs_acc++;
    @(posedge clk);
    edge_cnt++;
    if (rest) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc && pre_wr) m_write(a, be, wd);
      else if (acc) exp_q.push_back('{data: m_read(a), e: edge_cnt});
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Hold a command until the slave takes it (bounded), then go idle.
  task automatic send(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    bit taken;
    bit ok;
    taken = 1'b0;
    drive(rd, wr, a, be, wd);
    for (int i = 0; i < 20 && !taken; i++) begin
      ok = bus.request_ready;
      step();
      if (ok) taken = 1'b1;
    end
    idle();
    check_eq("send_accepted", {31'd0, taken}, 32'd1);
  endtask

  initial begin
    int          issued;
    int          first_acc;
    int          first_v;
    int          last_v;
    int          vcount;
    bit          ok;
    logic [31:0] a;

    idle();
    bus.resp_ready = 1'b1;
    rest = 1'b1;
    @(negedge clk);
    step();
    check_eq("reset_read_data", bus.read_data, 32'h0);
    rest = 1'b0;
    #1;
    check_eq("ready_after_reset", {31'd0, bus.request_ready}, 32'd1);

    for (int w = 0; w < WORDS; w++) send(1'b0, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom);

    send(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'hA5A5_1234);
    send(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    step();
    check_eq("wr_rd_valid", {31'd0, bus.read_data_valid}, 32'd1);
    check_eq("wr_rd_readback", bus.read_data, 32'hA5A5_1234);
    step();

    send(1'b0, 1'b1, BASE + 32'd12, 4'hF, 32'hFFFF_FFFF);
    send(1'b0, 1'b1, BASE + 32'd12, 4'b0001, 32'h0000_0011);
    send(1'b1, 1'b0, BASE + 32'd12, 4'h0, 32'h0);
    step();
    check_eq("byte_enable", bus.read_data, 32'hFFFF_FF11);
    step();

    bus.resp_ready = 1'b0;
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, BASE + 32'(4 * (20 + issued)), 4'h0, 32'h0);
      ok = bus.request_ready;
      step();
      if (ok) issued++;
    end
    check_eq("bp_accepted", 32'(issued), 32'd4);
    check_eq("bp_ready_low", {31'd0, bus.request_ready}, 32'd0);
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 20 && issued < 6; i++) begin
      drive(1'b1, 1'b0, BASE + 32'(4 * (20 + issued)), 4'h0, 32'h0);
      ok = bus.request_ready;
      step();
      if (ok) issued++;
    end
    idle();
    check_eq("bp_all_accepted", 32'(issued), 32'd6);
    repeat (8) step();

    send(1'b1, 1'b0, BASE + 32'd4096, 4'h0, 32'h0);
    step();
    check_eq("oor_valid", {31'd0, bus.read_data_valid}, 32'd1);
    check_eq("oor_data", bus.read_data, 32'h0);
    step();
    send(1'b1, 1'b1, BASE + 32'd20, 4'hF, 32'h0000_0055);
    repeat (3) step();
    check_eq("rw_no_resp", {31'd0, bus.read_data_valid}, 32'd0);
    send(1'b1, 1'b0, BASE + 32'd20, 4'h0, 32'h0);
    step();
    check_eq("rw_readback", bus.read_data, 32'h0000_0055);
    step();

    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, BASE + 32'(4 * (7 + i)), 4'h0, 32'h0);
    repeat (2) step();
    rest = 1'b1;
    step();
    check_eq("rst_valid_low", {31'd0, bus.read_data_valid}, 32'd0);
    check_eq("rst_ready_low", {31'd0, bus.request_ready}, 32'd0);
    check_eq("rst_data_zero", bus.read_data, 32'h0);
    rest = 1'b0;
    #1;
    check_eq("rst_ready_back", {31'd0, bus.request_ready}, 32'd1);
    bus.resp_ready = 1'b1;
    repeat (5) step();

    obs_acc   = 0;
    first_acc = -1;
    first_v   = -1;
    last_v    = -1;
    vcount    = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) drive(1'b1, 1'b0, BASE + 32'(4 * (100 + i)), 4'h0, 32'h0);
      else idle();
      step();
      if (first_acc < 0 && obs_acc > 0) first_acc = edge_cnt;
      if (bus.read_data_valid === 1'b1) begin
        vcount++;
        if (first_v < 0) first_v = edge_cnt;
        last_v = edge_cnt;
      end
    end
    check_eq("stream_accepted", 32'(obs_acc), 32'd16);
    check_eq("stream_responses", 32'(vcount), 32'd16);
    check_eq("stream_first_lat", 32'(first_v - first_acc), 32'd1);
    check_eq("stream_contiguous", 32'(last_v - first_v), 32'd15);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a,
            4'($urandom_range(0, 15)), $urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    bus.resp_ready = 1'b1;
    repeat (8) step();
    check_eq("drained", {31'd0, bus.read_data_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
